cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the result producers: ALU RS, branch RS, load/store queue and multiplier.
- Each source hands results to a one-entry holding register. Each cycle one held result is granted. The grant is registered onto the CDB broadcast consumed by the RS, ROB and regfile.
- Squashes held results whose ROB id is covered by a flush.

---
 rtl/cdb_arbiter_pkg.sv | 18 +
 rtl/cdb_arbiter_rr_picker.sv | 26 ++
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizes for the common-data-bus arbiter.
// The optional round-robin mode is selected with the CDB_ARB_RR_EN macro.
package cdb_arbiter_pkg;

    localparam int LEN_ID     = 3;
    localparam int SIZE_ROB   = 8;
    localparam int N_CDB_SRC  = 4;
    localparam int W_CDB_DATA = 32;

    // Source index on the bus uses the same encoding as inst_type.
    typedef enum logic [1:0] {
        cdb_src_alu  = 2'd0,
        cdb_src_br   = 2'd1,
        cdb_src_ls   = 2'd2,
        cdb_src_mult = 2'd3
    } cdb_src_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational rotate-priority picker: the first set request at or after base wins.
// With base tied to zero it is a plain lowest-index-first priority encoder.
module cdb_arbiter_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] base,
    output logic [N-1:0]         gnt
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   gnt_rot;

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        req_dbl = {req, req} >> base;
        req_rot = req_dbl[N-1:0];
        // Isolate the lowest set bit of the rotated request vector.
        gnt_rot = req_rot & (~req_rot + N'(1));
        gnt_dbl = {gnt_rot, gnt_rot} << base;
        gnt     = gnt_dbl[2*N-1:N];
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding register per producer, one grant per cycle, registered broadcast.
// Define CDB_ARB_RR_EN for round-robin arbitration; otherwise the lowest source index wins.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_SRC  = N_CDB_SRC,
    parameter int W_DATA = W_CDB_DATA,
    parameter int W_ID   = LEN_ID,
    parameter int N_ROB  = SIZE_ROB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         req_valid,
    input  logic [N_SRC*W_DATA-1:0]  req_data,
    input  logic [N_SRC*W_ID-1:0]    req_id,
    output logic [N_SRC-1:0]         req_ready,
    input  logic                     flush_en,
    input  logic [N_ROB-1:0]         flush_id,
    output logic                     cdb_valid,
    output logic [W_DATA-1:0]        cdb_data,
    output logic [W_ID-1:0]          cdb_id,
    output logic [$clog2(N_SRC)-1:0] cdb_src
);

    localparam int W_SRC = $clog2(N_SRC);

    logic [N_SRC-1:0]  hv;
    logic [W_DATA-1:0] hd  [N_SRC];
    logic [W_ID-1:0]   hid [N_SRC];

    logic [W_DATA-1:0] in_data [N_SRC];
    logic [W_ID-1:0]   in_id   [N_SRC];
    logic [N_SRC-1:0]  in_flushed;
    logic [N_SRC-1:0]  elig;
    logic [N_SRC-1:0]  gnt;
    logic [N_SRC-1:0]  capture;
    logic              any_gnt;
    logic [W_SRC-1:0]  gnt_idx;
    logic [W_DATA-1:0] gnt_data;
    logic [W_ID-1:0]   gnt_id;
    logic [W_SRC-1:0]  base;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            in_data[i]    = req_data[i*W_DATA +: W_DATA];
            in_id[i]      = req_id[i*W_ID +: W_ID];
            in_flushed[i] = flush_en && flush_id[in_id[i]];
            elig[i]       = hv[i] && !(flush_en && flush_id[hid[i]]);
        end
    end

`ifdef CDB_ARB_RR_EN
    logic [W_SRC-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any_gnt) begin
            ptr <= (gnt_idx == W_SRC'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign base = ptr;
`else
    assign base = '0;
`endif

    cdb_arbiter_rr_picker #(
        .N (N_SRC)
    ) u_picker (
        .req  (elig),
        .base (base),
        .gnt  (gnt)
    );

    // A granted entry frees its slot in the same cycle, so a source can stream one result per cycle.
    always_comb begin
        any_gnt  = |gnt;
        gnt_idx  = '0;
        gnt_data = '0;
        gnt_id   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            req_ready[i] = !hv[i] || gnt[i];
            capture[i]   = req_valid[i] && req_ready[i] && !in_flushed[i];
            gnt_data     = gnt_data | (hd[i] & {W_DATA{gnt[i]}});
            gnt_id       = gnt_id | (hid[i] & {W_ID{gnt[i]}});
            if (gnt[i]) begin
                gnt_idx = W_SRC'(i);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hv        <= '0;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_id    <= '0;
            cdb_src   <= '0;
        end else begin
            // Refill wins over grant; flushed or granted entries drop out.
            hv        <= capture | (elig & ~gnt);
            cdb_valid <= any_gnt;
            if (any_gnt) begin
                cdb_data <= gnt_data;
                cdb_id   <= gnt_id;
                cdb_src  <= gnt_idx;
            end
        end
    end

    // NOTE: payload registers carry no reset; hv alone says whether their contents mean anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (capture[i]) begin
                hd[i]  <= in_data[i];
                hid[i] <= in_id[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expectations follow CDB_ARB_RR_EN when it is defined.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

`ifdef CDB_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [11:0]  req_id;
    logic [3:0]   req_ready;
    logic         flush_en;
    logic [7:0]   flush_id;
    logic         cdb_valid;
    logic [31:0]  cdb_data;
    logic [2:0]   cdb_id;
    logic [1:0]   cdb_src;

    int vectors     = 0;
    int miscompares = 0;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_id    (req_id),
        .req_ready (req_ready),
        .flush_en  (flush_en),
        .flush_id  (flush_id),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_id    (cdb_id),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int s, input logic [31:0] d, input logic [2:0] id);
        req_valid[s]        = 1'b1;
        req_data[s*32 +: 32] = d;
        req_id[s*3 +: 3]     = id;
    endtask

    initial begin
        int exp_s;

        // Reset held for two edges with every source requesting.
        rst       = 1'b1;
        flush_en  = 1'b0;
        flush_id  = '0;
        req_valid = '0;
        req_data  = '0;
        req_id    = '0;
        for (int s = 0; s < 4; s++) offer(s, 32'h50 + s, 3'(s));
        tick();
        check("rst0_valid", 32'(cdb_valid), 0);
        check("rst0_id", 32'(cdb_id), 0);
        tick();
        check("rst1_valid", 32'(cdb_valid), 0);
        check("rst1_id", 32'(cdb_id), 0);
        check("rst1_src", 32'(cdb_src), 0);
        rst       = 1'b0;
        req_valid = '0;
        tick();
        check("post_rst_valid", 32'(cdb_valid), 0);

        // Single ALU result: one cycle in the hold register, then one broadcast cycle.
        offer(0, 32'h0000_00AA, 3'd3);
        @(negedge clk);
        check("single_ready", 32'(req_ready[0]), 1);
        tick();
        req_valid = '0;
        check("single_lat_valid", 32'(cdb_valid), 0);
        tick();
        check("single_valid", 32'(cdb_valid), 1);
        check("single_data", cdb_data, 32'hAA);
        check("single_id", 32'(cdb_id), 3);
        check("single_src", 32'(cdb_src), 32'(cdb_src_alu));
        tick();
        check("single_one_cycle", 32'(cdb_valid), 0);
        check("single_data_hold", cdb_data, 32'hAA);

        // Back-to-back ALU results with ids 1, 2, 4.
        offer(0, 32'h101, 3'd1);
        @(negedge clk);
        check("b2b_ready0", 32'(req_ready[0]), 1);
        tick();
        offer(0, 32'h102, 3'd2);
        @(negedge clk);
        check("b2b_ready1", 32'(req_ready[0]), 1);
        tick();
        check("b2b_id1", 32'(cdb_id), 1);
        check("b2b_valid1", 32'(cdb_valid), 1);
        offer(0, 32'h104, 3'd4);
        @(negedge clk);
        check("b2b_ready2", 32'(req_ready[0]), 1);
        tick();
        req_valid = '0;
        check("b2b_id2", 32'(cdb_id), 2);
        check("b2b_data2", cdb_data, 32'h102);
        tick();
        check("b2b_id4", 32'(cdb_id), 4);
        check("b2b_valid4", 32'(cdb_valid), 1);
        tick();
        check("b2b_idle", 32'(cdb_valid), 0);

        // LS entry id 5 flushed while the branch entry is granted.
        offer(1, 32'hB2, 3'd2);
        offer(2, 32'hC5, 3'd5);
        tick();
        req_valid = '0;
        flush_en  = 1'b1;
        flush_id  = 8'b0010_0000;
        @(negedge clk);
        check("fh_ready_ls_busy", 32'(req_ready[2]), 0);
        tick();
        flush_en = 1'b0;
        flush_id = '0;
        check("fh_br_valid", 32'(cdb_valid), 1);
        check("fh_br_id", 32'(cdb_id), 2);
        check("fh_br_src", 32'(cdb_src), 32'(cdb_src_br));
        @(negedge clk);
        check("fh_ready_ls_free", 32'(req_ready[2]), 1);
        tick();
        check("fh_no_id5", 32'(cdb_valid), 0);

        // Mult id 6 flushed on arrival; ALU id 1 passes.
        offer(3, 32'hD6, 3'd6);
        offer(0, 32'hE1, 3'd1);
        flush_en = 1'b1;
        flush_id = 8'b0100_0000;
        @(negedge clk);
        check("fa_ready_mult", 32'(req_ready[3]), 1);
        check("fa_ready_alu", 32'(req_ready[0]), 1);
        tick();
        req_valid = '0;
        flush_en  = 1'b0;
        flush_id  = '0;
        check("fa_lat_valid", 32'(cdb_valid), 0);
        tick();
        check("fa_alu_valid", 32'(cdb_valid), 1);
        check("fa_alu_id", 32'(cdb_id), 1);
        check("fa_alu_data", cdb_data, 32'hE1);
        tick();
        check("fa_no_id6", 32'(cdb_valid), 0);

        // Contention: reset first so arbitration starts from source 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) offer(s, 32'h100 + s, 3'(s));
        tick();
        check("cont_fill_valid", 32'(cdb_valid), 0);
        for (int k = 0; k < 8; k++) begin
            exp_s = RR_MODE ? (k % 4) : 0;
            @(negedge clk);
            check($sformatf("cont_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << exp_s));
            tick();
            check($sformatf("cont_valid_%0d", k), 32'(cdb_valid), 1);
            check($sformatf("cont_src_%0d", k), 32'(cdb_src), exp_s);
            check($sformatf("cont_id_%0d", k), 32'(cdb_id), exp_s);
        end

        // Reset with every hold register full: nothing may come out afterwards.
        rst       = 1'b1;
        req_valid = '0;
        tick();
        check("midrst_valid", 32'(cdb_valid), 0);
        rst = 1'b0;
        tick();
        check("midrst_after0", 32'(cdb_valid), 0);
        tick();
        check("midrst_after1", 32'(cdb_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
